// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared FSM encoding and error-cause codes for the dmem controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] err_cause_t;

    localparam err_cause_t ERR_NONE     = 2'd0;
    localparam err_cause_t ERR_MISALIGN = 2'd1;
    localparam err_cause_t ERR_CONFLICT = 2'd2;
    localparam err_cause_t ERR_TIMEOUT  = 2'd3;

    localparam int CNT_W = 8;

    // Counter value at which a BUSY access is abandoned.
    function automatic logic [CNT_W-1:0] expire_value(input int timeout);
        return CNT_W'(timeout - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
// ============================================================================
// dmem_if  : core-side load/store request bundle plus external memory req/ack
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dmem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  memRead, memWrite, addr, wdata, mem_rdata, mem_ack,
        output rdata, stall, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output memRead, memWrite, addr, wdata, mem_rdata, mem_ack,
        input  rdata, stall, err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
// ============================================================================
// dmem_timeout_cnt : 8-bit BUSY-cycle counter, expire_o high at TIMEOUT-1
// Revision         : 1.0
// ============================================================================
`default_nettype none

module dmem_timeout_cnt
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expire_o
);

    localparam logic [CNT_W-1:0] c_expire = expire_value(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at the expire value so it can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != c_expire)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == c_expire);

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : turns memory-stage load/store into a req/ack access, stalls core
// Revision  : 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  wire logic clk,
    input  wire logic rst_n,
    dmem_if.slave     bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              req_q,   req_d;
    logic              we_q,    we_d;
    logic              err_q,   err_d;
    err_cause_t        cause_q, cause_d;

    logic w_single;
    logic w_conflict;
    logic w_misalign;
    logic w_stall;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_cnt_expire;

    assign w_single   = bus.memRead ^ bus.memWrite;
    assign w_conflict = bus.memRead & bus.memWrite;
    assign w_misalign = w_single & bus.addr[0];

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (w_cnt_clr),
        .en_i     (w_cnt_en),
        .expire_o (w_cnt_expire)
    );

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        req_d     = req_q;
        we_d      = we_q;
        err_d     = 1'b0;
        cause_d   = ERR_NONE;
        w_stall   = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_conflict) begin
                    err_d   = 1'b1;
                    cause_d = ERR_CONFLICT;
                end else if (w_misalign) begin
                    err_d   = 1'b1;
                    cause_d = ERR_MISALIGN;
                end else if (w_single) begin
                    w_stall   = 1'b1;
                    addr_d    = {bus.addr[ADDR_W-1:1], 1'b0};
                    wdata_d   = bus.wdata;
                    we_d      = bus.memWrite;
                    req_d     = 1'b1;
                    w_cnt_clr = 1'b1;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                w_stall  = 1'b1;
                w_cnt_en = 1'b1;
                // A same-cycle ack beats the timeout.
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else if (w_cnt_expire) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cause_d = ERR_TIMEOUT;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = '1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cause_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cause_q <= cause_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.stall     = rst_n & w_stall;
    assign bus.err       = err_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    a_req_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
        req_q |-> (state_q == ST_BUSY));

    a_err_has_cause: assert property (@(posedge clk) disable iff (!rst_n)
        err_q |-> (cause_q != ERR_NONE));

endmodule

`default_nettype wire
